// File: rtl/hdshk_pulse_queue.sv
// clk_a-side event queue that launches one pulse at a time into a handshake pulse synchronizer.
// Define HPQ_DROP_CNT_EN to add the saturating dropped-event counter (drop_cnt).
module hdshk_pulse_queue #(
   parameter int CNT_W  = 4,
   parameter int DROP_W = 8
) (
   input  logic              clk_a,
   input  logic              rst_n,
   input  logic              evt_in,
   input  logic              busy,
   input  logic              clr_ovf,
   output logic              sig_a,
   output logic [CNT_W-1:0]  pending,
   output logic              full,
`ifdef HPQ_DROP_CNT_EN
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
`else
   output logic              overflow
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] pending_reg, pending_next;
   logic             sig_a_reg;
   logic             overflow_reg, overflow_next;
   logic             launch;
   logic             accept;
   logic             drop;

   always_comb begin
      state_next = state_reg;
      launch     = 1'b0;
      case (state_reg)
         IDLE: begin
            if ((pending_reg != '0) && !busy) begin
               launch     = 1'b1;
               state_next = WAIT_HI;
            end
         end
         // busy only rises one edge after sig_a, so wait to see it high first
         WAIT_HI: if (busy)  state_next = WAIT_LO;
         WAIT_LO: if (!busy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign full   = (pending_reg == PEND_MAX);
   // A launch in the same edge frees a slot, so a full queue can still accept.
   assign accept = evt_in && (!full || launch);
   assign drop   = evt_in && full && !launch;

   always_comb begin
      pending_next = pending_reg;
      if (accept && !launch)
         pending_next = pending_reg + CNT_W'(1);
      else if (!accept && launch)
         pending_next = pending_reg - CNT_W'(1);
   end

   always_comb begin
      overflow_next = overflow_reg;
      if (drop)
         overflow_next = 1'b1;
      else if (clr_ovf)
         overflow_next = 1'b0;
   end

   always_ff @(posedge clk_a) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         pending_reg  <= '0;
         sig_a_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pending_reg  <= pending_next;
         sig_a_reg    <= launch;
         overflow_reg <= overflow_next;
      end
   end

   assign sig_a    = sig_a_reg;
   assign pending  = pending_reg;
   assign overflow = overflow_reg;

`ifdef HPQ_DROP_CNT_EN
   logic [DROP_W-1:0] drop_cnt_reg;

   always_ff @(posedge clk_a) begin
      if (!rst_n)
         drop_cnt_reg <= '0;
      else if (drop && (drop_cnt_reg != '1))
         drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
   end

   assign drop_cnt = drop_cnt_reg;
`else
   // Without the drop counter DROP_W has no logic; keep it referenced for a uniform parameter list.
   if (DROP_W < 1) begin : g_drop_w_unused
   end
`endif

endmodule

// File: tb/tb_hdshk_pulse_queue.sv
// Randomized self-checking bench for hdshk_pulse_queue against a queue-level reference model,
// with a behavioural synchronizer driving busy.
`timescale 1ns/1ps
module tb_hdshk_pulse_queue;

   localparam int CNT_W  = 3;
   localparam int DROP_W = 3;
   localparam int PMAX   = (1 << CNT_W) - 1;
   localparam int DMAX   = (1 << DROP_W) - 1;

   logic             clk_a = 1'b0;
   logic             rst_n;
   logic             evt_in;
   logic             busy;
   logic             clr_ovf;
   logic             sig_a;
   logic [CNT_W-1:0] pending;
   logic             full;
   logic             overflow;
`ifdef HPQ_DROP_CNT_EN
   logic [DROP_W-1:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // reference model: event count, sticky flag, drops, and whether a launch is still outstanding
   int m_cnt, m_drops;
   bit m_sig, m_ovf, m_out, m_ack;

   // synchronizer model
   int busy_left = 0;
   bit stuck     = 1'b0;
   int launches_seen = 0;

   always #5 clk_a = ~clk_a;

   hdshk_pulse_queue #(
      .CNT_W  (CNT_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk_a    (clk_a),
      .rst_n    (rst_n),
      .evt_in   (evt_in),
      .busy     (busy),
      .clr_ovf  (clr_ovf),
      .sig_a    (sig_a),
      .pending  (pending),
      .full     (full),
`ifdef HPQ_DROP_CNT_EN
      .overflow (overflow),
      .drop_cnt (drop_cnt)
`else
      .overflow (overflow)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge of the reference model, computed from the queue rules.
   task automatic model_edge();
      bit launch;
      if (!rst_n) begin
         m_cnt = 0; m_drops = 0; m_sig = 0; m_ovf = 0; m_out = 0; m_ack = 0;
         return;
      end
      launch = !m_out && (m_cnt > 0) && !busy;
      if (evt_in && (m_cnt == PMAX) && !launch) begin
         m_ovf = 1;
         if (m_drops < DMAX) m_drops++;
      end else begin
         if (clr_ovf) m_ovf = 0;
         if (evt_in) m_cnt++;
      end
      if (launch) m_cnt--;
      if (launch) begin
         m_out = 1; m_ack = 0;
      end else if (m_out && !m_ack && busy) begin
         m_ack = 1;
      end else if (m_out && m_ack && !busy) begin
         m_out = 0;
      end
      m_sig = launch;
   endtask

   task automatic cycle();
      bit sig_pre;
      sig_pre = sig_a;
      @(posedge clk_a);
      model_edge();
      #1;
      cyc++;
      check_val("sig_a", sig_a, m_sig);
      check_val("pending", pending, m_cnt);
      check_val("full", full, (m_cnt == PMAX));
      check_val("overflow", overflow, m_ovf);
`ifdef HPQ_DROP_CNT_EN
      check_val("drop_cnt", drop_cnt, m_drops);
`endif
      if (sig_a === 1'b1) begin
         launches_seen++;
         $display("[TB] cycle %0d launch #%0d pending=%0d", cyc, launches_seen, pending);
      end
      // synchronizer: busy rises the edge after it sees sig_a, holds for a round trip
      if (busy_left > 0)
         busy_left--;
      else if (sig_pre)
         busy_left = $urandom_range(2, 6);
      busy = stuck || (busy_left > 0);
   endtask

   task automatic drain();
      int  n;
      bit  done;
      stuck   = 0;
      evt_in  = 0;
      clr_ovf = 0;
      busy    = (busy_left > 0);
      n = 0;
      done = (m_cnt == 0) && !m_out && !busy;
      while (!done && n < 300) begin
         cycle();
         n++;
         done = (m_cnt == 0) && !m_out && !busy;
      end
      check_val("drain_done", done, 1);
   endtask

   initial begin
      int peak;
      int stuck_left;
      int dens;

      rst_n = 0; evt_in = 0; busy = 0; clr_ovf = 0;
      repeat (2) cycle();
      check_val("rst_pending", pending, 0);
      check_val("rst_sig_a", sig_a, 0);
      check_val("rst_overflow", overflow, 0);
      rst_n = 1;
      cycle();

      // single event: pulse two edges after the evt_in edge
      evt_in = 1; cycle(); evt_in = 0;
      check_val("single_pend", pending, 1);
      cycle();
      check_val("single_sig", sig_a, 1);
      check_val("single_pend0", pending, 0);
      drain();

      // accept and launch in the same edge
      evt_in = 1; cycle(); cycle();
      check_val("acc_launch_sig", sig_a, 1);
      check_val("acc_launch_pend", pending, 1);
      drain();

      // burst of 5
      launches_seen = 0; peak = 0;
      evt_in = 1;
      repeat (5) begin
         cycle();
         if (int'(pending) > peak) peak = int'(pending);
      end
      drain();
      check_val("burst_peak", peak, 4);
      check_val("burst_launches", launches_seen, 5);
      check_val("burst_pend_end", pending, 0);

      // saturation with busy stuck high, then clr_ovf vs new drop
      stuck = 1; busy = 1; evt_in = 1;
      repeat (PMAX + 3) cycle();
      check_val("sat_pending", pending, PMAX);
      check_val("sat_full", full, 1);
      check_val("sat_overflow", overflow, 1);
`ifdef HPQ_DROP_CNT_EN
      check_val("sat_drop_cnt", drop_cnt, 3);
`endif
      clr_ovf = 1; cycle();
      check_val("clr_vs_drop", overflow, 1);
      evt_in = 0; cycle();
      check_val("clr_alone", overflow, 0);
      clr_ovf = 0;
      launches_seen = 0;
      drain();
      check_val("sat_launches", launches_seen, PMAX);

      // reset while waiting for busy to fall with two events queued
      evt_in = 1; cycle(); evt_in = 0; cycle();
      stuck = 1; busy = 1;
      evt_in = 1; repeat (2) cycle(); evt_in = 0; cycle();
      check_val("mid_pend_before", pending, 2);
      rst_n = 0; cycle(); rst_n = 1;
      check_val("mid_rst_pend", pending, 0);
      check_val("mid_rst_sig", sig_a, 0);
      check_val("mid_rst_ovf", overflow, 0);
      launches_seen = 0;
      repeat (5) cycle();
      stuck = 0; busy = (busy_left > 0);
      repeat (10) cycle();
      check_val("mid_no_launch", launches_seen, 0);
      evt_in = 1; cycle(); evt_in = 0;
      drain();
      check_val("mid_new_launch", launches_seen, 1);

      // randomized traffic with stuck-busy episodes and occasional resets
      stuck_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (stuck_left > 0) stuck_left--;
         else if ($urandom_range(0, 199) == 0) stuck_left = $urandom_range(10, 60);
         stuck   = (stuck_left > 0);
         busy    = stuck || (busy_left > 0);
         dens    = ((i % 512) < 256) ? 20 : 70;
         evt_in  = ($urandom_range(0, 99) < dens);
         clr_ovf = ($urandom_range(0, 15) == 0);
         rst_n   = ($urandom_range(0, 399) != 0);
         cycle();
      end
      rst_n = 1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
